// File: rtl/result_uart_tx_pkg.sv
// Shared constants, state encodings and the hex/line formatting helpers
// for the result UART logger.
package result_uart_tx_pkg;

  localparam int CLKS_PER_BIT_DEF = 868;   // 100 MHz / 115200 baud
  localparam int LINE_BYTES       = 13;

  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;

  // Byte serializer states: start bit, 8 data bits, stop bit.
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // Line sequencer states; FIN is the single done cycle.
  typedef enum logic [1:0] {
    LN_IDLE,
    LN_SEND,
    LN_FIN
  } line_state_e;

  // Uppercase ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return ASCII_ZERO + {4'h0, n};
    return ASCII_A + {4'h0, n} - 8'd10;
  endfunction

  // Byte idx of the line "RRRRRRRR FF\r\n".
  function automatic logic [7:0] line_byte(input logic [3:0]  idx,
                                           input logic [31:0] res,
                                           input logic [4:0]  flg);
    logic [31:0] sh;
    logic [7:0]  b;
    sh = res << {idx[2:0], 2'b00};
    case (idx)
      4'd0, 4'd1, 4'd2, 4'd3,
      4'd4, 4'd5, 4'd6, 4'd7: b = hex_ascii(sh[31:28]);
      4'd8:                   b = ASCII_SP;
      4'd9:                   b = hex_ascii({3'b000, flg[4]});
      4'd10:                  b = hex_ascii(flg[3:0]);
      4'd11:                  b = ASCII_CR;
      default:                b = ASCII_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/result_uart_tx_byte.sv
// 8N1 byte serializer with baud timer. in_ready is also high in the last
// cycle of the stop bit so a following byte starts with no idle gap.
module uart_tx_byte
  import result_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       tx
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  tx_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        tx_q, tx_d;
  logic        bit_end;

  // Next-state: bit timing, data shifting and byte hand-off.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    bit_end  = (timer_q == T_LAST);
    in_ready = (state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_end);

    if (state_q != TX_IDLE) timer_d = bit_end ? '0 : timer_q + TW'(1);

    case (state_q)
      TX_START: if (bit_end) begin
        state_d = TX_DATA;
        bit_d   = 3'd0;
      end
      TX_DATA: if (bit_end) begin
        if (bit_q == 3'd7) begin
          state_d = TX_STOP;
        end else begin
          bit_d = bit_q + 3'd1;
          sh_d  = sh_q >> 1;
        end
      end
      TX_STOP: if (bit_end) state_d = TX_IDLE;
      default: ;
    endcase

    if (in_valid && in_ready) begin
      state_d = TX_START;
      sh_d    = in_data;
      timer_d = '0;
      bit_d   = 3'd0;
    end

    // Registered line level follows the state being entered.
    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = sh_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // State register; line idles high in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      timer_q <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/result_uart_tx.sv
// Captures an ALU result/flags pair on start and streams it as one
// "RRRRRRRR FF\r\n" ASCII line over an 8N1 UART.
module result_uart_tx
  import result_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] result,
  input  logic [4:0]  flags,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  line_state_e state_q, state_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  flg_q, flg_d;

  logic        accept;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        ser_ready;

  // Line sequencer: accept, feed bytes back-to-back, then one done cycle.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    res_d      = res_q;
    flg_d      = flg_q;
    byte_valid = 1'b0;
    byte_data  = line_byte(byte_idx_q + 4'd1, res_q, flg_q);
    accept     = start && (state_q != LN_SEND);

    case (state_q)
      LN_SEND: if (ser_ready) begin
        if (byte_idx_q < 4'(LINE_BYTES - 1)) begin
          byte_valid = 1'b1;
          byte_idx_d = byte_idx_q + 4'd1;
        end else begin
          state_d = LN_FIN;
        end
      end
      LN_FIN:  state_d = LN_IDLE;
      default: ;
    endcase

    // First byte comes straight from the inputs so the start bit
    // appears right after the accepting edge.
    if (accept) begin
      state_d    = LN_SEND;
      byte_idx_d = 4'd0;
      res_d      = result;
      flg_d      = flags;
      byte_valid = 1'b1;
      byte_data  = line_byte(4'd0, result, flags);
    end
  end

  // Sequencer and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LN_IDLE;
      byte_idx_q <= 4'd0;
      res_q      <= 32'h0;
      flg_q      <= 5'h0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      res_q      <= res_d;
      flg_q      <= flg_d;
    end
  end

  assign busy = (state_q == LN_SEND);
  assign done = (state_q == LN_FIN);

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .in_valid (byte_valid),
    .in_data  (byte_data),
    .in_ready (ser_ready),
    .tx       (tx)
  );

endmodule
